// File: rtl/conversor_bin_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift add-3), one add-3/shift step per clock.
// Start/done handshake, optional two's-complement input and overflow flag; results are registered.
module conversor_bin_bcd_secuencial #(
    parameter int ANCHO_BIN = 8,
    parameter int DIGITOS   = 3,
    parameter int CON_SIGNO = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic [ANCHO_BIN-1:0]   numBinario,
    output logic                   ocupado,
    output logic                   listo,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   negativo,
    output logic                   desborde
);

    localparam int BCD_W = 4 * DIGITOS;
    localparam int SR_W  = BCD_W + ANCHO_BIN;
    localparam int CNT_W = $clog2(ANCHO_BIN) + 1;

    typedef enum logic {
        REPOSO,
        CONVIRTIENDO
    } estado_t;

    estado_t              r_estado;
    logic [SR_W-1:0]      r_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_signo;
    logic                 r_ovf;

    logic                 w_signo;
    logic [ANCHO_BIN-1:0] w_mag;
    logic [SR_W-1:0]      w_ajustado;
    logic [SR_W-1:0]      w_desplazado;
    logic                 w_carry;

    // Zero has MSB=0, so it can never be flagged negative.
    assign w_signo = (CON_SIGNO != 0) && numBinario[ANCHO_BIN-1];
    assign w_mag   = w_signo ? (~numBinario + ANCHO_BIN'(1)) : numBinario;

    always_comb begin
        w_ajustado = r_sr;
        for (int k = 0; k < DIGITOS; k++) begin
            if (r_sr[ANCHO_BIN+4*k +: 4] > 4'd4)
                w_ajustado[ANCHO_BIN+4*k +: 4] = r_sr[ANCHO_BIN+4*k +: 4] + 4'd3;
        end
    end

    // The bit leaving the top digit is lost from the result and marks overflow.
    assign w_carry      = w_ajustado[SR_W-1];
    assign w_desplazado = {w_ajustado[SR_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= REPOSO;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_signo  <= 1'b0;
            r_ovf    <= 1'b0;
            ocupado  <= 1'b0;
            listo    <= 1'b0;
            bcd      <= '0;
            negativo <= 1'b0;
            desborde <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_sr     <= {{BCD_W{1'b0}}, w_mag};
                        r_cnt    <= '0;
                        r_signo  <= w_signo;
                        r_ovf    <= 1'b0;
                        ocupado  <= 1'b1;
                        r_estado <= CONVIRTIENDO;
                    end
                end
                CONVIRTIENDO: begin
                    r_sr  <= w_desplazado;
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_ovf <= r_ovf | w_carry;
                    if (r_cnt == CNT_W'(ANCHO_BIN - 1)) begin
                        bcd      <= w_desplazado[SR_W-1 -: BCD_W];
                        negativo <= r_signo;
                        desborde <= r_ovf | w_carry;
                        listo    <= 1'b1;
                        ocupado  <= 1'b0;
                        r_estado <= REPOSO;
                    end
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bin_bcd_secuencial.sv
// Bench for conversor_bin_bcd_secuencial: three instances (unsigned 3 digits, signed 3 digits,
// unsigned 2 digits) with a per-instance expected-result queue checked on every listo pulse.
module tb_conversor_bin_bcd_secuencial;

    typedef struct packed {
        logic [11:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ini_a = 1'b0, ini_b = 1'b0, ini_c = 1'b0;
    logic [7:0]  num_a = '0, num_b = '0, num_c = '0;
    logic        ocu_a, ocu_b, ocu_c;
    logic        lis_a, lis_b, lis_c;
    logic [11:0] bcd_a, bcd_b;
    logic [7:0]  bcd_c;
    logic        neg_a, neg_b, neg_c;
    logic        ovf_a, ovf_b, ovf_c;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    conversor_bin_bcd_secuencial #(.ANCHO_BIN(8), .DIGITOS(3), .CON_SIGNO(0)) u_a (
        .clk(clk), .rst(rst), .inicio(ini_a), .numBinario(num_a), .ocupado(ocu_a),
        .listo(lis_a), .bcd(bcd_a), .negativo(neg_a), .desborde(ovf_a));
    conversor_bin_bcd_secuencial #(.ANCHO_BIN(8), .DIGITOS(3), .CON_SIGNO(1)) u_b (
        .clk(clk), .rst(rst), .inicio(ini_b), .numBinario(num_b), .ocupado(ocu_b),
        .listo(lis_b), .bcd(bcd_b), .negativo(neg_b), .desborde(ovf_b));
    conversor_bin_bcd_secuencial #(.ANCHO_BIN(8), .DIGITOS(2), .CON_SIGNO(0)) u_c (
        .clk(clk), .rst(rst), .inicio(ini_c), .numBinario(num_c), .ocupado(ocu_c),
        .listo(lis_c), .bcd(bcd_c), .negativo(neg_c), .desborde(ovf_c));

    // Decimal reference: digits of the magnitude modulo 10^dig, overflow if anything is left.
    function automatic exp_t modelo(input logic [7:0] v, input bit signo, input int dig);
        exp_t e;
        int   m;
        e.neg = signo && v[7];
        m     = e.neg ? (256 - int'(v)) : int'(v);
        e.bcd = '0;
        for (int k = 0; k < dig; k++) begin
            e.bcd[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        e.ovf = (m != 0);
        return e;
    endfunction

    function automatic logic f_listo(input int s);
        return (s == 0) ? lis_a : (s == 1) ? lis_b : lis_c;
    endfunction

    function automatic logic f_ocup(input int s);
        return (s == 0) ? ocu_a : (s == 1) ? ocu_b : ocu_c;
    endfunction

    task automatic set_in(input int s, input logic ini, input logic [7:0] v);
        case (s)
            0:       begin ini_a = ini; num_a = v; end
            1:       begin ini_b = ini; num_b = v; end
            default: begin ini_c = ini; num_c = v; end
        endcase
    endtask

    task automatic push(input int s, input logic [7:0] v);
        case (s)
            0:       q_a.push_back(modelo(v, 1'b0, 3));
            1:       q_b.push_back(modelo(v, 1'b1, 3));
            default: q_c.push_back(modelo(v, 1'b0, 2));
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One conversion: checks 8 busy cycles and listo exactly 8 cycles after the accept edge.
    task automatic run(input int s, input logic [7:0] v);
        int n_ocu;
        int lat;
        lat   = -1;
        n_ocu = 0;
        set_in(s, 1'b1, v);
        push(s, v);
        @(negedge clk);
        set_in(s, 1'b0, v);
        if (f_ocup(s)) n_ocu++;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (f_listo(s)) begin
                lat = n;
                break;
            end
            if (f_ocup(s)) n_ocu++;
        end
        check("latency", lat, 8);
        check("ocupado_cycles", n_ocu, 8);
        check("ocupado_at_listo", f_ocup(s), 1'b0);
    endtask

    task automatic wait_listo(input int s, output int cycles);
        cycles = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (f_listo(s)) begin
                cycles = n;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (lis_a) begin
            n_checks++;
            assert (q_a.size() > 0) else begin
                n_errors++;
                $error("FAIL listo_a_unexpected: queued %0d expected >0", q_a.size());
            end
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                n_checks++;
                assert ({bcd_a, neg_a, ovf_a} === {e.bcd, e.neg, e.ovf}) else begin
                    n_errors++;
                    $error("FAIL result_a: observed %h/%b/%b expected %h/%b/%b",
                           bcd_a, neg_a, ovf_a, e.bcd, e.neg, e.ovf);
                end
            end
        end
        if (lis_b) begin
            n_checks++;
            assert (q_b.size() > 0) else begin
                n_errors++;
                $error("FAIL listo_b_unexpected: queued %0d expected >0", q_b.size());
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                n_checks++;
                assert ({bcd_b, neg_b, ovf_b} === {e.bcd, e.neg, e.ovf}) else begin
                    n_errors++;
                    $error("FAIL result_b: observed %h/%b/%b expected %h/%b/%b",
                           bcd_b, neg_b, ovf_b, e.bcd, e.neg, e.ovf);
                end
            end
        end
        if (lis_c) begin
            n_checks++;
            assert (q_c.size() > 0) else begin
                n_errors++;
                $error("FAIL listo_c_unexpected: queued %0d expected >0", q_c.size());
            end
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                n_checks++;
                assert ({4'h0, bcd_c, neg_c, ovf_c} === {e.bcd, e.neg, e.ovf}) else begin
                    n_errors++;
                    $error("FAIL result_c: observed %h/%b/%b expected %h/%b/%b",
                           bcd_c, neg_c, ovf_c, e.bcd, e.neg, e.ovf);
                end
            end
        end
    end

    initial begin
        int cyc;
        logic [7:0] rv;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_bcd_a", bcd_a, 12'h000);
        check("rst_ocupado_a", ocu_a, 1'b0);
        check("rst_listo_a", lis_a, 1'b0);
        check("rst_negativo_b", neg_b, 1'b0);
        check("rst_desborde_c", ovf_c, 1'b0);

        // T1 / T2 unsigned
        run(0, 8'd255);
        repeat (5) @(negedge clk);
        check("hold_bcd_a", bcd_a, 12'h255);
        run(0, 8'd0);
        run(0, 8'd100);
        run(0, 8'd9);
        run(0, 8'd10);
        run(0, 8'd199);

        // T3 signed
        run(1, 8'h80);
        run(1, 8'hF9);
        run(1, 8'h7F);
        run(1, 8'h00);
        run(1, 8'hFF);

        // T4 two digits
        run(2, 8'd255);
        run(2, 8'd99);
        run(2, 8'd100);

        for (int i = 0; i < 4; i++) begin
            rv = 8'($urandom_range(0, 255));
            run(0, rv);
            run(1, rv);
            run(2, rv);
        end

        // T5: second start 3 cycles after accept is ignored
        set_in(0, 1'b1, 8'd37);
        push(0, 8'd37);
        @(negedge clk);
        set_in(0, 1'b0, 8'd37);
        repeat (2) @(negedge clk);
        set_in(0, 1'b1, 8'd200);
        @(negedge clk);
        set_in(0, 1'b0, 8'd200);
        wait_listo(0, cyc);
        check("ignored_start_latency", cyc, 5);
        repeat (12) @(negedge clk);

        // T5: inicio held high -> one result every 9 cycles
        set_in(0, 1'b1, 8'd123);
        push(0, 8'd123);
        push(0, 8'd123);
        push(0, 8'd123);
        wait_listo(0, cyc);
        check("held_first_latency", cyc, 9);
        wait_listo(0, cyc);
        check("held_period_1", cyc, 9);
        wait_listo(0, cyc);
        check("held_period_2", cyc, 9);
        set_in(0, 1'b0, 8'd123);
        repeat (12) @(negedge clk);
        check("held_stopped", ocu_a, 1'b0);

        // T6: reset 4 cycles into a conversion aborts it
        set_in(0, 1'b1, 8'd200);
        @(negedge clk);
        set_in(0, 1'b0, 8'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ocupado", ocu_a, 1'b0);
        check("abort_bcd", bcd_a, 12'h000);
        check("abort_listo", lis_a, 1'b0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run(0, 8'd42);

        repeat (3) @(negedge clk);
        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        check("queue_c_empty", q_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
